// File: rtl/vid_issue.sv
// vid_issue: splits one vid.v command into per-word beats for the vID pipe.
// Define VID_VSTART_EN to add cmd_vstart (partial-start commands).
module vid_issue #(
  parameter int REQ_DATA_WIDTH    = 64,
  parameter int REQ_BYTE_EN_WIDTH = REQ_DATA_WIDTH/8,
  parameter int REQ_ADDR_WIDTH    = 5,
  parameter int SEW_WIDTH         = 2,
  parameter int VL_WIDTH          = 12,
  parameter bit ENABLE_64_BIT     = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [SEW_WIDTH-1:0]         cmd_sew,
  input  logic [VL_WIDTH-1:0]          cmd_vl,
  input  logic [REQ_ADDR_WIDTH-1:0]    cmd_addr,
`ifdef VID_VSTART_EN
  input  logic [VL_WIDTH-1:0]          cmd_vstart,
`endif
  input  logic                         in_stall,
  output logic                         out_valid,
  output logic [SEW_WIDTH-1:0]         out_sew,
  output logic [VL_WIDTH-1:0]          out_start_idx,
  output logic [REQ_ADDR_WIDTH-1:0]    out_addr,
  output logic [REQ_BYTE_EN_WIDTH-1:0] out_byte_en,
  output logic                         out_last,
  output logic                         done,
  output logic                         err
);

  localparam int IW  = VL_WIDTH + 1;
  localparam int BW  = REQ_BYTE_EN_WIDTH;
  localparam int AW  = REQ_ADDR_WIDTH;
  localparam int SW  = SEW_WIDTH;
  localparam int LGB = $clog2(BW);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_ISSUE = 1'b1;

  logic [0:0]    state;
  logic [SW-1:0] s_sew;
  logic [IW-1:0] s_vl;
  logic [IW-1:0] idx;
  logic [AW-1:0] addr;
`ifdef VID_VSTART_EN
  logic [IW-1:0] s_vs;
`endif

  logic          idle;
  logic          hs;
  logic          bad;
  logic          empty;
  logic          start;
  logic          emit;
  logic          c_last;
  logic [SW-1:0] c_sew;
  logic [IW-1:0] in_vs;
  logic [IW-1:0] c_vl;
  logic [IW-1:0] c_vs;
  logic [IW-1:0] c_idx;
  logic [IW-1:0] epb;
  logic [IW-1:0] al_off;
  logic [IW-1:0] rem;
  logic [IW-1:0] n;
  logic [IW-1:0] skip;
  logic [IW-1:0] nb;
  logic [IW-1:0] sb;
  logic [AW-1:0] c_addr;
  logic [7:0]    sh;
  logic [BW-1:0] c_be;

  assign cmd_ready = (state == S_IDLE);

  // In IDLE the beat is formed straight from the command inputs so the
  // first beat leaves one cycle after the handshake.
  always_comb begin
    idle = (state == S_IDLE);
    hs   = cmd_valid && idle;
`ifdef VID_VSTART_EN
    in_vs = {1'b0, cmd_vstart};
    c_vs  = idle ? in_vs : s_vs;
`else
    in_vs = '0;
    c_vs  = '0;
`endif
    bad    = !ENABLE_64_BIT && (cmd_sew == SW'(3));
    empty  = (in_vs >= {1'b0, cmd_vl});
    start  = hs && !bad && !empty;
    c_sew  = idle ? cmd_sew : s_sew;
    c_vl   = idle ? {1'b0, cmd_vl} : s_vl;
    sh     = 8'(LGB) - 8'(c_sew);
    epb    = IW'(1) << sh;
    al_off = c_vs >> sh;
    c_idx  = idle ? (al_off << sh) : idx;
    c_addr = idle ? (cmd_addr + AW'(al_off)) : addr;
    rem    = c_vl - c_idx;
    n      = (rem < epb) ? rem : epb;
    skip   = (c_vs > c_idx) ? (c_vs - c_idx) : '0;
    nb     = n << c_sew;
    sb     = skip << c_sew;
    for (int b = 0; b < BW; b++) begin
      c_be[b] = (IW'(b) < nb) && (IW'(b) >= sb);
    end
    c_last = ((c_idx + epb) >= c_vl);
    emit   = idle ? (start && !in_stall) : !in_stall;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      s_sew         <= '0;
      s_vl          <= '0;
      idx           <= '0;
      addr          <= '0;
`ifdef VID_VSTART_EN
      s_vs          <= '0;
`endif
      out_valid     <= 1'b0;
      out_sew       <= '0;
      out_start_idx <= '0;
      out_addr      <= '0;
      out_byte_en   <= '0;
      out_last      <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      out_valid     <= emit;
      out_sew       <= emit ? c_sew : '0;
      out_start_idx <= emit ? c_idx[VL_WIDTH-1:0] : '0;
      out_addr      <= emit ? c_addr : '0;
      out_byte_en   <= emit ? c_be : '0;
      out_last      <= emit && c_last;
      done          <= (emit && c_last) || (hs && (bad || empty));
      err           <= hs && bad;

      if (hs) begin
        s_sew <= cmd_sew;
        s_vl  <= {1'b0, cmd_vl};
`ifdef VID_VSTART_EN
        s_vs  <= in_vs;
`endif
      end

      if (emit) begin
        idx  <= c_idx + epb;
        addr <= c_addr + AW'(1);
      end else if (hs) begin
        idx  <= c_idx;
        addr <= c_addr;
      end

      // Leaving ISSUE on the last beat keeps cmd_ready up while it is shown.
      if (idle) begin
        if (start && !(emit && c_last)) state <= S_ISSUE;
      end else if (emit && c_last) begin
        state <= S_IDLE;
      end
    end
  end

endmodule
